// File: rtl/conv_25d_stream.sv
// Streaming 2.5D convolution layer.
// Per-channel line buffers feed a KxK sliding window. Each kernel lane then
// multiplies the window against its coefficients and reduces the products
// to one signed accumulator. Three stages: window, multiply, adder tree.
// Every stage advances only while the output register is free or draining.

module conv_25d_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int TAPS   = 18
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     ld_mul,
  input  logic                     ld_out,
  input  logic [TAPS*DATA_W-1:0]   win,
  input  logic [TAPS*DATA_W-1:0]   coef,
  output logic [ACC_W-1:0]         result
);
  localparam int PW = 2*DATA_W + 1;

  logic signed [PW-1:0]    prod [TAPS];
  logic signed [ACC_W-1:0] sum;

  // S2: zero-extended pixel times sign-extended coefficient, one product per tap
  always_ff @(posedge clock) begin
    if (en && ld_mul) begin
      for (int t = 0; t < TAPS; t++)
        prod[t] <= PW'($signed({1'b0, win[t*DATA_W +: DATA_W]})) *
                   PW'($signed(coef[t*DATA_W +: DATA_W]));
    end
  end

  // Adder tree across taps and channels; wraps modulo 2^ACC_W
  always_comb begin
    sum = '0;
    for (int t = 0; t < TAPS; t++)
      sum = sum + ACC_W'(prod[t]);
  end

  // S3: output register, only reloaded when a real window arrives
  always_ff @(posedge clock) begin
    if (reset)
      result <= '0;
    else if (en && ld_out)
      result <= sum;
  end
endmodule

module conv_25d_stream #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 32,
  parameter int Z_DEPTH     = 4,
  parameter int NUM_KERNELS = 2,
  parameter int K           = 3,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_W*Z_DEPTH-1:0]                pixel_in,
  input  logic [DATA_W*NUM_KERNELS*K*K*Z_DEPTH-1:0] kernel,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [ACC_W*NUM_KERNELS-1:0]             pixel_out,
  output logic                                     frame_done
);
  localparam int TAPS   = K*K*Z_DEPTH;
  localparam int STAGES = 3;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);

  typedef logic [Z_DEPTH-1:0][DATA_W-1:0] pix_t;

  logic              en, acc, row_end, frame_end;
  logic              vld_s0, lst_s0;
  logic [STAGES:1]   vld_pipe, lst_pipe;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  pix_t              pix_in;
  pix_t              lb [K-1][IMG_W];
  pix_t [K-1:0]      col;
  // [z][ky][kx] flattens to tap index (z*K+ky)*K+kx, matching the kernel layout
  logic [Z_DEPTH-1:0][K-1:0][K-1:0][DATA_W-1:0] win;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign acc       = in_valid && en && !reset;
  assign pix_in    = pixel_in;
  assign row_end   = (x == XW'(IMG_W-1));
  assign frame_end = row_end && (y == YW'(IMG_H-1));
  assign vld_s0    = acc && (x >= XW'(K-1)) && (y >= YW'(K-1));
  assign lst_s0    = acc && frame_end;

  // Raster position and valid/last flags; flags march on every enabled cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_s0};
      lst_pipe <= {lst_pipe[STAGES-1:1], lst_s0};
      if (acc) begin
        if (row_end) begin
          x <= '0;
          y <= frame_end ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // Current column: oldest row at ky=0, accepted pixel at ky=K-1
  always_comb begin
    col[K-1] = pix_in;
    for (int j = 0; j < K-1; j++)
      col[j] = lb[j][x];
  end

  // S1: push column into line buffers and shift it into the window.
  // Buffers are never cleared; border gating hides stale contents.
  always_ff @(posedge clock) begin
    if (acc) begin
      for (int j = 0; j < K-1; j++)
        lb[j][x] <= col[j+1];
      for (int z = 0; z < Z_DEPTH; z++) begin
        for (int ky = 0; ky < K; ky++) begin
          for (int kx = 0; kx < K-1; kx++)
            win[z][ky][kx] <= win[z][ky][kx+1];
          win[z][ky][K-1] <= col[ky][z];
        end
      end
    end
  end

  generate
    for (genvar n = 0; n < NUM_KERNELS; n++) begin : g_lane
      conv_25d_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .TAPS(TAPS)) u_lane (
        .clock  (clock),
        .reset  (reset),
        .en     (en),
        .ld_mul (vld_pipe[1]),
        .ld_out (vld_pipe[2]),
        .win    (win),
        .coef   (kernel[n*TAPS*DATA_W +: TAPS*DATA_W]),
        .result (pixel_out[n*ACC_W +: ACC_W])
      );
    end
  endgenerate

  assign out_valid  = vld_pipe[STAGES];
  assign frame_done = lst_pipe[STAGES];
endmodule

// File: tb/tb_conv_25d_stream.sv
// Randomized bench for conv_25d_stream (K=3, 4x4 image, Z=2, 2 kernels)
// against a direct window-sum reference model.
module tb_conv_25d_stream;
  localparam int DATA_W = 8, ACC_W = 32, Z = 2, N = 2, K = 3, W = 4, H = 4;

  logic clock = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, frame_done;
  logic [DATA_W*Z-1:0]       pixel_in = '0;
  logic [DATA_W*N*K*K*Z-1:0] kernel = '0;
  logic [ACC_W*N-1:0]        pixel_out;

  conv_25d_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W), .Z_DEPTH(Z), .NUM_KERNELS(N),
                    .K(K), .IMG_W(W), .IMG_H(H)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .kernel(kernel), .out_valid(out_valid),
    .out_ready(out_ready), .pixel_out(pixel_out), .frame_done(frame_done));

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int v0; int v1; bit fd; int tag; } exp_t;
  typedef struct { logic [31:0] l0; logic [31:0] l1; } lit_t;
  exp_t exp_q[$];
  lit_t lit_q[$];
  int kv [N][Z][K][K];
  int img [H][W][Z];
  int mx = 0, my = 0, en_edges = 0;
  exp_t me, ce;

  function automatic int model_out(input int n, input int x, input int y);
    int s = 0;
    for (int z = 0; z < Z; z++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          s += img[y-K+1+ky][x-K+1+kx][z] * kv[n][z][ky][kx];
    return s;
  endfunction

  task automatic load_kernel();
    for (int n = 0; n < N; n++)
      for (int z = 0; z < Z; z++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            kernel[(((n*Z+z)*K+ky)*K+kx)*DATA_W +: DATA_W] = kv[n][z][ky][kx][7:0];
  endtask

  task automatic set_kernel(input int mode);
    for (int n = 0; n < N; n++)
      for (int z = 0; z < Z; z++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            case (mode)
              0: kv[n][z][ky][kx] = 1;
              1: kv[n][z][ky][kx] = -1;
              2: kv[n][z][ky][kx] = (n == 0 && z == 0 && ky == 1 && kx == 1) ? 1 : 0;
              default: kv[n][z][ky][kx] = int'($urandom_range(0, 255)) - 128;
            endcase
    load_kernel();
  endtask

  // Model sees every accepted beat; en_edges counts enabled clock edges
  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      mx = 0; my = 0;
    end else begin
      if (in_ready) en_edges++;
      if (in_valid && in_ready) begin
        for (int z = 0; z < Z; z++) img[my][mx][z] = int'(pixel_in[z*DATA_W +: DATA_W]);
        if (mx >= K-1 && my >= K-1) begin
          me.v0 = model_out(0, mx, my);
          me.v1 = model_out(1, mx, my);
          me.fd = (mx == W-1 && my == H-1);
          me.tag = en_edges;
          exp_q.push_back(me);
        end
        if (mx == W-1) begin mx = 0; my = (my == H-1) ? 0 : my + 1; end
        else mx++;
      end
    end
  end

  // ---------------- compare process ----------------
  bit prev_stall = 0;
  logic [63:0] prev_pix;
  logic prev_fd;
  int n_res = 0, n_fd = 0, n_stall = 0;
  lit_t lt;

  always @(negedge clock) begin
    if (prev_stall) begin
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
      chk("stall_hold_data", pixel_out, prev_pix);
      chk("stall_hold_fd", 64'(frame_done), 64'(prev_fd));
    end
    prev_stall = 0;
    if (out_valid && !out_ready) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      prev_stall = 1; prev_pix = pixel_out; prev_fd = frame_done; n_stall++;
    end
    if (!out_valid) chk("fd_without_valid", 64'(frame_done), 64'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_result", 64'd1, 64'd0);
      else begin
        ce = exp_q.pop_front();
        chk("lane0", 64'(pixel_out[31:0]), 64'($unsigned(ce.v0)));
        chk("lane1", 64'(pixel_out[63:32]), 64'($unsigned(ce.v1)));
        chk("frame_done", 64'(frame_done), 64'(ce.fd));
        chk("latency_en_cycles", 64'(en_edges - ce.tag), 64'd2);
        n_res++;
        if (frame_done) n_fd++;
        if (lit_q.size() > 0) begin
          lt = lit_q.pop_front();
          chk("literal_lane0", 64'(pixel_out[31:0]), 64'(lt.l0));
          chk("literal_lane1", 64'(pixel_out[63:32]), 64'(lt.l1));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_beat(input logic [15:0] pix, input int gap);
    bit ok = 0;
    int t = 0;
    repeat (gap) begin @(posedge clock); #1; end
    in_valid = 1; pixel_in = pix;
    while (!ok && t < 200) begin
      @(posedge clock);
      ok = in_ready && !reset;
      #1; t++;
    end
    chk("beat_accepted", 64'(ok), 64'd1);
    in_valid = 0;
  endtask

  task automatic run_beats(input int mode, input int gap_max, input int nbeats);
    logic [15:0] p;
    for (int i = 0; i < nbeats; i++) begin
      int x = i % W, y = i / W;
      case (mode)
        0: p = {8'd1, 8'd1};
        1: p = {8'd255, 8'd255};
        2: p = {8'd200, 8'(x + 4*y)};
        default: p = 16'($urandom);
      endcase
      send_beat(p, gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() > 0 || out_valid) && t < 100) begin @(posedge clock); #1; t++; end
    chk("drain_complete", 64'(t < 100), 64'd1);
  endtask

  task automatic push_lit(input logic [31:0] a, input logic [31:0] b);
    lt.l0 = a; lt.l1 = b; lit_q.push_back(lt);
  endtask

  int r0, f0, s0;
  bit stop_rnd;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_frame_done", 64'(frame_done), 64'd0);
    chk("reset_pixel_out", pixel_out, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    reset = 0;

    // 1: all ones -> 18 per lane
    set_kernel(0);
    for (int i = 0; i < 4; i++) push_lit(32'd18, 32'd18);
    r0 = n_res; f0 = n_fd;
    run_beats(0, 0, W*H); drain();
    chk("t1_count", 64'(n_res - r0), 64'd4);
    chk("t1_fd", 64'(n_fd - f0), 64'd1);

    // 2: 255 pixels, -1 taps -> -4590
    set_kernel(1);
    for (int i = 0; i < 4; i++) push_lit(32'hFFFFEE12, 32'hFFFFEE12);
    r0 = n_res;
    run_beats(1, 0, W*H); drain();
    chk("t2_count", 64'(n_res - r0), 64'd4);

    // 3: identity center tap
    set_kernel(2);
    push_lit(32'd5, 32'd0); push_lit(32'd6, 32'd0);
    push_lit(32'd9, 32'd0); push_lit(32'd10, 32'd0);
    r0 = n_res;
    run_beats(2, 0, W*H); drain();
    chk("t3_count", 64'(n_res - r0), 64'd4);

    // 4: 5-cycle output stall while input keeps offering
    set_kernel(3);
    r0 = n_res; s0 = n_stall;
    fork
      run_beats(3, 0, W*H);
      begin
        int t = 0;
        while (!out_valid && t < 50) begin @(posedge clock); #1; t++; end
        out_ready = 0;
        repeat (5) begin @(posedge clock); #1; end
        out_ready = 1;
      end
    join
    drain();
    chk("t4_count", 64'(n_res - r0), 64'd4);
    chk("t4_stalled", 64'(n_stall - s0 >= 5), 64'd1);

    // 5: mid-frame reset after beat 11, beat offered during reset is dropped
    set_kernel(0);
    r0 = n_res;
    run_beats(0, 0, 12);
    reset = 1; in_valid = 1; pixel_in = 16'($urandom);
    repeat (2) begin @(posedge clock); #1; end
    reset = 0; in_valid = 0;
    repeat (6) begin @(posedge clock); #1; end
    chk("t5_aborted_none", 64'(n_res - r0), 64'd0);
    for (int i = 0; i < 4; i++) push_lit(32'd18, 32'd18);
    f0 = n_fd;
    run_beats(0, 0, W*H); drain();
    chk("t5_count", 64'(n_res - r0), 64'd4);
    chk("t5_fd", 64'(n_fd - f0), 64'd1);

    // 6: two frames, random kernel, random gaps, random out_ready
    set_kernel(3);
    r0 = n_res; f0 = n_fd; stop_rnd = 0;
    fork
      begin run_beats(3, 3, 2*W*H); stop_rnd = 1; end
      begin
        while (!stop_rnd) begin
          @(posedge clock); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain();
    chk("t6_count", 64'(n_res - r0), 64'd8);
    chk("t6_fd", 64'(n_fd - f0), 64'd2);
    chk("literals_consumed", 64'(lit_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
    $fatal(1);
  end
endmodule

// File: doc/conv_25d_stream.md
# conv_25d_stream

Streaming, parametrised 2.5D convolution layer. It accepts one Z_DEPTH-channel pixel vector per handshake beat in raster order. It builds a K×K sliding window per channel with internal line buffers, multiplies each window against NUM_KERNELS signed kernels, and sums across window taps and Z channels into one accumulator per kernel. It sits between feature-map layers and adds what the fixed-size convolution layer lacked:

- configurable kernel size, data width and image geometry;
- valid/ready backpressure;
- border gating, so only fully-populated windows are emitted;
- frame tracking.

## Interface

Parameters:
- DATA_W, 8, pixel and kernel coefficient width
- ACC_W, 32, accumulator and output width per kernel
- Z_DEPTH, 4, input channels (kernels of the previous layer)
- NUM_KERNELS, 2, output channels
- K, 3, square kernel edge (K ≥ 2)
- IMG_W, 28, pixels per row (IMG_W ≥ K)
- IMG_H, 28, rows per frame (IMG_H ≥ K)

Ports:
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  pixel_in holds a valid beat
- in_ready  out  1  block accepts a beat this cycle
- pixel_in  in  DATA_W*Z_DEPTH  channel z at bits [z*DATA_W +: DATA_W], unsigned
- kernel  in  DATA_W*NUM_KERNELS*K*K*Z_DEPTH  signed coefficients; index ((n*Z_DEPTH+z)*K+ky)*K+kx, bits [idx*DATA_W +: DATA_W]
- out_valid  out  1  pixel_out holds a result
- out_ready  in  1  downstream accepts result
- pixel_out  out  ACC_W*NUM_KERNELS  kernel n result at [n*ACC_W +: ACC_W], signed
- frame_done  out  1  qualifies the last result of a frame

## Operation

- Global enable: en = !out_valid || out_ready. in_ready = en. A beat is accepted when in_valid && in_ready.
- All pipeline registers, counters and line buffers advance only on en. When en is low, everything holds.
- Position counters x (0..IMG_W-1) and y (0..IMG_H-1) advance per accepted beat.
  - x wraps to 0 and increments y.
  - At (IMG_W-1, IMG_H-1), both wrap to 0, starting the next frame with no gap.
- Line buffers: K-1 rows of IMG_W entries per channel, plus a K-wide column shift window per row.
- Window orientation: ky=0 is the oldest row and kx=0 the oldest column. The accepted pixel is tap (K-1, K-1).
- A window is valid when the accepted beat has x ≥ K-1 and y ≥ K-1. Other beats only fill buffers.
- Output count: (IMG_W-K+1)*(IMG_H-K+1) results per frame.
- Arithmetic:
  - Pixels are zero-extended and kernels sign-extended.
  - Each product is DATA_W*2+1 bits signed.
  - Summation over K*K*Z_DEPTH taps is sign-extended to ACC_W, with two's-complement wrap (no saturation).
- Kernel is sampled in the multiply stage and must stay stable for the whole frame. Changes mid-frame give undefined results for in-flight windows only.
- frame_done is set together with out_valid for the window ending at (IMG_W-1, IMG_H-1). It is 0 otherwise.
- Pipeline stages, each advancing on en:
  - S1: window register plus valid/last flags.
  - S2: multiply array.
  - S3: adder tree across taps and Z, into output registers.
- Reset:
  - x=0, y=0; all valid flags, out_valid and frame_done are 0; pixel_out is 0.
  - Line buffer contents are not cleared; the border gate masks stale data.
  - Reset mid-frame discards in-flight results. The next accepted beat is (0,0).

## Timing

- Latency: the result appears on out_valid in the 3rd en cycle after the accepting cycle of the window-completing beat. With out_ready held high, that is exactly 3 clocks.
- Throughput: one beat per clock when out_ready=1.
- out_ready low with out_valid high:
  - in_ready drops combinationally in the same cycle.
  - pixel_out, out_valid and frame_done hold unchanged until the cycle out_ready is high.
- in_valid gaps insert bubbles. Counters do not advance and no result is produced for a gap.
- reset has priority over handshakes in the same cycle.
- in_ready is 1 during reset (out_valid=0), but a beat offered in a reset cycle is not accepted.

## Test plan

Small configuration: K=3, IMG_W=IMG_H=4, Z_DEPTH=2, NUM_KERNELS=2.

1. **All-ones.** All pixels 1, all kernel taps 1, out_ready=1, 16 beats back-to-back.
   - Exactly 4 results, each lane = 18.
   - First out_valid 3 clocks after beat index 10 (x=2, y=2) is accepted; frame_done only on the 4th.
2. **Negative wrap.** Pixels 255, all taps -1 (0xFF).
   - Every lane = -4590 = 0xFFFFEE12.
3. **Identity.** Kernel 0, channel 0 has center tap (1,1)=1, all else 0; channel 0 pixel = x+4y, channel 1 = 200.
   - Outputs in order: 5, 6, 9, 10; kernel 1 lane = 0.
4. **Backpressure.** out_ready held low 5 cycles while out_valid=1, with in_valid=1 throughout.
   - in_ready=0 during the stall; pixel_out stable.
   - After release, all 4 results delivered in order with none lost or duplicated.
5. **Mid-frame reset.** Assert reset after beat 11, then send a full fresh frame of all-ones.
   - No result from the aborted frame.
   - Fresh frame yields exactly 4 results of 18 with correct latency.
6. **Back-to-back frames with random in_valid gaps.** Two frames.
   - 8 results total, frame_done pulses exactly twice.
   - Values match a reference model.
